// File: rtl/reg_bank_32x32_if.sv
// Write/clear port bundle for reg_bank_32x32.
// Latency: n/a (signal grouping only).
// Backpressure: master holds wr_en until wr_ready; busy marks an in-flight clear.
// Ports: wr_en/wr_addr/wr_data/wr_be/clr (master->slave), wr_ready/busy (slave->master).
interface reg_bank_32x32_if #(
  parameter int WIDTH = 32
);
  logic               wr_en;
  logic [4:0]         wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH/8-1:0] wr_be;
  logic               wr_ready;
  logic               clr;
  logic               busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, clr,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, clr,
    output wr_ready, busy
  );
endinterface

// File: rtl/reg_bank_32x32.sv
// 32-entry register storage with one byte-maskable write port and a sequenced bulk clear.
// Latency: a write or clear step is visible on Rn one cycle after the accepting edge.
// Backpressure: wr_ready drops for the whole clear sequence; requester holds wr_en until it returns.
// Ports: clk, rst (async, active-high); bus (slave modport: write + clr handshake);
//        R0..R31 drive register contents straight from storage to the read-select muxes.
module reg_bank_32x32 #(
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_bank_32x32_if.slave        bus,
  output logic [WIDTH-1:0]       R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
  output logic [WIDTH-1:0]       R8,  R9,  R10, R11, R12, R13, R14, R15,
  output logic [WIDTH-1:0]       R16, R17, R18, R19, R20, R21, R22, R23,
  output logic [WIDTH-1:0]       R24, R25, R26, R27, R28, R29, R30, R31
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_idx;
  logic [4:0]       w_idx_nxt;
  logic [WIDTH-1:0] r_regs [32];
  logic             w_wr_fire;
  logic             w_clr_step;

  // Handshake outputs come from registered state only.
  assign bus.wr_ready = (r_state == IDLE);
  assign bus.busy     = (r_state == CLEAR);

  assign w_wr_fire  = bus.wr_en && (r_state == IDLE);
  assign w_clr_step = (r_state == CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (bus.clr) begin
          w_state_nxt = CLEAR;
          // R0 needs no clearing when it is hardwired to zero.
          w_idx_nxt   = (ZERO_REG != 0) ? 5'd1 : 5'd0;
        end
      end
      CLEAR: begin
        // clr is ignored here: no restart, no extension.
        w_idx_nxt = r_idx + 5'd1;
        if (r_idx == 5'd31) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Clear and write are mutually exclusive by state, so priority order is moot.
  // Entry 0 is never written when ZERO_REG is set, so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_clr_step && (r_idx == 5'(i))) begin
          r_regs[i] <= '0;
        end else if (w_wr_fire && (bus.wr_addr == 5'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
          for (int b = 0; b < WIDTH/8; b++) begin
            if (bus.wr_be[b]) begin
              r_regs[i][8*b +: 8] <= bus.wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign R0  = r_regs[0];
  assign R1  = r_regs[1];
  assign R2  = r_regs[2];
  assign R3  = r_regs[3];
  assign R4  = r_regs[4];
  assign R5  = r_regs[5];
  assign R6  = r_regs[6];
  assign R7  = r_regs[7];
  assign R8  = r_regs[8];
  assign R9  = r_regs[9];
  assign R10 = r_regs[10];
  assign R11 = r_regs[11];
  assign R12 = r_regs[12];
  assign R13 = r_regs[13];
  assign R14 = r_regs[14];
  assign R15 = r_regs[15];
  assign R16 = r_regs[16];
  assign R17 = r_regs[17];
  assign R18 = r_regs[18];
  assign R19 = r_regs[19];
  assign R20 = r_regs[20];
  assign R21 = r_regs[21];
  assign R22 = r_regs[22];
  assign R23 = r_regs[23];
  assign R24 = r_regs[24];
  assign R25 = r_regs[25];
  assign R26 = r_regs[26];
  assign R27 = r_regs[27];
  assign R28 = r_regs[28];
  assign R29 = r_regs[29];
  assign R30 = r_regs[30];
  assign R31 = r_regs[31];

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Bench for reg_bank_32x32: one instance with R0 hardwired to zero (A), one without (B).
// Stimulus pushes expected observations into a queue; a negedge monitor drains and compares.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_reg_bank_32x32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_32x32_if #(.WIDTH(32)) bus_a ();
  reg_bank_32x32_if #(.WIDTH(32)) bus_b ();

  logic [31:0][31:0] ra;
  logic [31:0][31:0] rb;

  reg_bank_32x32 #(.WIDTH(32), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave),
    .R0(ra[0]),   .R1(ra[1]),   .R2(ra[2]),   .R3(ra[3]),   .R4(ra[4]),   .R5(ra[5]),
    .R6(ra[6]),   .R7(ra[7]),   .R8(ra[8]),   .R9(ra[9]),   .R10(ra[10]), .R11(ra[11]),
    .R12(ra[12]), .R13(ra[13]), .R14(ra[14]), .R15(ra[15]), .R16(ra[16]), .R17(ra[17]),
    .R18(ra[18]), .R19(ra[19]), .R20(ra[20]), .R21(ra[21]), .R22(ra[22]), .R23(ra[23]),
    .R24(ra[24]), .R25(ra[25]), .R26(ra[26]), .R27(ra[27]), .R28(ra[28]), .R29(ra[29]),
    .R30(ra[30]), .R31(ra[31])
  );

  reg_bank_32x32 #(.WIDTH(32), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave),
    .R0(rb[0]),   .R1(rb[1]),   .R2(rb[2]),   .R3(rb[3]),   .R4(rb[4]),   .R5(rb[5]),
    .R6(rb[6]),   .R7(rb[7]),   .R8(rb[8]),   .R9(rb[9]),   .R10(rb[10]), .R11(rb[11]),
    .R12(rb[12]), .R13(rb[13]), .R14(rb[14]), .R15(rb[15]), .R16(rb[16]), .R17(rb[17]),
    .R18(rb[18]), .R19(rb[19]), .R20(rb[20]), .R21(rb[21]), .R22(rb[22]), .R23(rb[23]),
    .R24(rb[24]), .R25(rb[25]), .R26(rb[26]), .R27(rb[27]), .R28(rb[28]), .R29(rb[29]),
    .R30(rb[30]), .R31(rb[31])
  );

  // kind: 0 = register idx, 1 = busy, 2 = wr_ready
  typedef struct {
    string       name;
    int          dut;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] peek(int dut, int kind, int idx);
    logic [31:0] v;
    v = '0;
    if (kind == 0)      v = (dut == 0) ? ra[idx] : rb[idx];
    else if (kind == 1) v = {31'd0, (dut == 0) ? bus_a.busy : bus_b.busy};
    else                v = {31'd0, (dut == 0) ? bus_a.wr_ready : bus_b.wr_ready};
    return v;
  endfunction

  function automatic void exp_reg(string nm, int dut, int idx, logic [31:0] v);
    q.push_back('{nm, dut, 0, idx, v});
  endfunction

  function automatic void exp_busy(string nm, int dut, logic v);
    q.push_back('{nm, dut, 1, 0, {31'd0, v}});
  endfunction

  function automatic void exp_rdy(string nm, int dut, logic v);
    q.push_back('{nm, dut, 2, 0, {31'd0, v}});
  endfunction

  function automatic void exp_all_zero(string nm, int dut);
    for (int i = 0; i < 32; i++) exp_reg($sformatf("%s_R%0d", nm, i), dut, i, 32'h0);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, expv);
    end
  endtask

  // Monitor: every falling edge, check everything the stimulus has queued so far.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = peek(e.dut, e.kind, e.idx);
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s dut%0d: got %08h expected %08h", e.name, e.dut, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(string nm, int dut, int max_cycles);
    int n;
    n = 0;
    while ((peek(dut, 2, 0) !== 32'h1) && (n < max_cycles)) begin
      step();
      n++;
    end
    chk({nm, "_timeout"}, peek(dut, 2, 0), 32'h1);
  endtask

  task automatic wr(int dut, int addr, logic [31:0] d, logic [3:0] be);
    if (dut == 0) begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'(addr); bus_a.wr_data = d; bus_a.wr_be = be;
    end else begin
      bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'(addr); bus_b.wr_data = d; bus_b.wr_be = be;
    end
    step();
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
  endtask

  initial begin
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.wr_be = '0; bus_a.clr = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.wr_be = '0; bus_b.clr = 1'b0;

    // Reset state on both instances.
    #2;
    chk("rst_now_busy_a", {31'd0, bus_a.busy}, 32'h0);
    chk("rst_now_rdy_a", {31'd0, bus_a.wr_ready}, 32'h1);
    chk("rst_now_busy_b", {31'd0, bus_b.busy}, 32'h0);
    chk("rst_now_rdy_b", {31'd0, bus_b.wr_ready}, 32'h1);
    chk("rst_now_R5_a", ra[5], 32'h0);
    chk("rst_now_R0_b", rb[0], 32'h0);
    exp_all_zero("rst", 0);
    exp_all_zero("rst", 1);
    exp_busy("rst_busy", 0, 1'b0); exp_rdy("rst_rdy", 0, 1'b1);
    exp_busy("rst_busy", 1, 1'b0); exp_rdy("rst_rdy", 1, 1'b1);
    #10;
    rst = 1'b0;

    // 1: full-word write.
    wr(0, 5, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 32; i++)
      exp_reg($sformatf("t1_R%0d", i), 0, i, (i == 5) ? 32'hDEADBEEF : 32'h0);

    // 2: byte-masked write, bytes 0 and 2 only.
    wr(0, 5, 32'h11223344, 4'b0101);
    exp_reg("t2_R5", 0, 5, 32'hDE22BE44);

    // 3: write to R0 with and without hardwiring; wr_be=0 is a no-op.
    exp_rdy("t3_rdy_a", 0, 1'b1);
    wr(0, 0, 32'hFFFFFFFF, 4'hF);
    exp_reg("t3_R0_zero", 0, 0, 32'h0);
    exp_rdy("t3_rdy_b", 1, 1'b1);
    wr(1, 0, 32'hFFFFFFFF, 4'hF);
    exp_reg("t3_R0_plain", 1, 0, 32'hFFFFFFFF);
    wr(1, 2, 32'h12345678, 4'h0);
    exp_reg("t3_be0_R2", 1, 2, 32'h0);

    // 4: fill 1..31, clear, with a write held across the sequence.
    for (int n = 1; n < 32; n++) wr(0, n, n * 32'h01010101, 4'hF);
    exp_reg("t4_fill_R31", 0, 31, 32'h1F1F1F1F);
    bus_a.clr = 1'b1;
    step();
    bus_a.clr = 1'b0;
    exp_busy("t4_busy0", 0, 1'b1);
    exp_rdy("t4_rdy0", 0, 1'b0);
    exp_reg("t4_R1_k0", 0, 1, 32'h01010101);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd3; bus_a.wr_data = 32'h55AA55AA; bus_a.wr_be = 4'hF;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k < 31) begin
        exp_busy($sformatf("t4_busy_k%0d", k), 0, 1'b1);
        exp_rdy($sformatf("t4_rdy_k%0d", k), 0, 1'b0);
        exp_reg($sformatf("t4_R%0d_zeroed", k), 0, k, 32'h0);
        exp_reg($sformatf("t4_R%0d_kept", k + 1), 0, k + 1, (k + 1) * 32'h01010101);
      end else begin
        exp_busy("t4_busy_end", 0, 1'b0);
        exp_rdy("t4_rdy_end", 0, 1'b1);
        exp_all_zero("t4_end", 0);
      end
    end
    wait_ready("t4_wait", 0, 4);
    step();
    bus_a.wr_en = 1'b0;
    exp_reg("t4_held_wr_R3", 0, 3, 32'h55AA55AA);

    // 5: write and clear in the same cycle; second clr mid-sequence is ignored.
    bus_a.clr = 1'b1;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'hCAFEF00D; bus_a.wr_be = 4'hF;
    step();
    bus_a.clr = 1'b0;
    bus_a.wr_en = 1'b0;
    exp_reg("t5_R7_k0", 0, 7, 32'hCAFEF00D);
    exp_busy("t5_busy_k0", 0, 1'b1);
    for (int k = 1; k <= 31; k++) begin
      if (k == 10) bus_a.clr = 1'b1;
      step();
      bus_a.clr = 1'b0;
      if (k < 7)  exp_reg($sformatf("t5_R7_k%0d", k), 0, 7, 32'hCAFEF00D);
      if (k == 7) exp_reg("t5_R7_zeroed", 0, 7, 32'h0);
      if (k == 3) exp_reg("t5_R3_zeroed", 0, 3, 32'h0);
      if (k == 30) exp_busy("t5_busy_k30", 0, 1'b1);
      if (k == 31) begin
        exp_busy("t5_busy_end", 0, 1'b0);
        exp_rdy("t5_rdy_end", 0, 1'b1);
      end
    end
    wait_ready("t5_wait", 0, 4);

    // 6: async reset in the middle of a clear (index 10).
    wr(0, 20, 32'h12345678, 4'hF);
    exp_reg("t6_R20_loaded", 0, 20, 32'h12345678);
    bus_a.clr = 1'b1;
    step();
    bus_a.clr = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    exp_reg("t6_R20_pre", 0, 20, 32'h12345678);
    exp_busy("t6_busy_pre", 0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_all_zero("t6_rst", 0);
    exp_busy("t6_busy_rst", 0, 1'b0);
    exp_rdy("t6_rdy_rst", 0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    wait_ready("t6_wait", 0, 2);
    wr(0, 9, 32'hA5A5A5A5, 4'hF);
    exp_reg("t6_R9_after", 0, 9, 32'hA5A5A5A5);
    exp_reg("t6_R20_after", 0, 20, 32'h0);
    exp_busy("t6_busy_after", 0, 1'b0);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
